// File: rtl/ula_seq.sv
// Clocked processor ALU: registered result/flags, multi-cycle restoring divider
// behind a start/busy/done handshake, and a small scratch memory with a spare read port.
module ula_seq #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int MEM_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [ADDR_W-1:0] rd_endereco,
  output logic [WIDTH-1:0]  saidaULA,
  output logic              zero,
  output logic              carry,
  output logic              div_by_zero,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  mem_rdata
);
  localparam logic [0:0] IDLE = 1'b0, DIV = 1'b1;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_DIV = 4'b0100, OP_ST = 4'b1100, OP_LD = 4'b1101;

  logic [0:0]         state;
  logic [WIDTH-1:0]   memoria [MEM_DEPTH];
  logic [WIDTH-1:0]   quo, rem, divisor;
  logic [CNT_W-1:0]   cnt;

  function automatic logic in_range(input logic [ADDR_W-1:0] ad);
    return 32'(ad) < MEM_DEPTH;
  endfunction

  assign mem_rdata = in_range(rd_endereco) ? memoria[rd_endereco] : '0;

  // single-cycle datapath; the divide case here only covers b==0
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res, ld_data;
  logic               cy, dbz;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign ld_data = in_range(endereco) ? memoria[endereco] : '0;

  always_comb begin
    res = '0;
    cy  = 1'b0;
    dbz = 1'b0;
    case (opcode)
      4'b0001: begin res = sum[WIDTH-1:0];  cy = sum[WIDTH];  end
      4'b0010: begin res = diff[WIDTH-1:0]; cy = diff[WIDTH]; end
      4'b0011: begin res = prod[WIDTH-1:0]; cy = |prod[2*WIDTH-1:WIDTH]; end
      OP_DIV:  begin res = '1; dbz = 1'b1; end
      4'b0101: res = a & b;
      4'b0110: res = a | b;
      4'b0111: res = ~a;
      4'b1000: res = a ^ b;
      4'b1001: res = a ~^ b;
      4'b1010: res = a;
      4'b1011: res = ~a;
      OP_ST:   res = a;
      OP_LD:   res = ld_data;
      default: res = '0;
    endcase
  end

  // one restoring step: shift the next dividend bit into the partial remainder
  logic [WIDTH:0]   shifted, trial;
  logic             ge;
  logic [WIDTH-1:0] quo_nx, rem_nx;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign ge      = ~trial[WIDTH];
  assign rem_nx  = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nx  = {quo[WIDTH-2:0], ge};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      saidaULA    <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) memoria[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (opcode == OP_DIV && b != '0) begin
            quo     <= a;
            rem     <= '0;
            divisor <= b;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= DIV;
          end else begin
            saidaULA    <= res;
            carry       <= cy;
            zero        <= (res == '0);
            div_by_zero <= dbz;
            done        <= 1'b1;
            if (opcode == OP_ST && in_range(endereco)) memoria[endereco] <= a;
          end
        end
        DIV: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            saidaULA    <= quo_nx;
            zero        <= (quo_nx == '0);
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: directed scenarios plus random ops against an arithmetic model.
module tb_ula_seq;
  localparam int W = 8, AW = 4, DEPTH = 12;

  logic          clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0]    opcode = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic [AW-1:0] endereco = '0, rd_endereco = '0;
  logic [W-1:0]  saidaULA, mem_rdata;
  logic          zero, carry, div_by_zero, busy, done;

  int n_cmp = 0, n_bad = 0;
  int mref [16];

  ula_seq #(.WIDTH(W), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
    .endereco(endereco), .rd_endereco(rd_endereco), .saidaULA(saidaULA), .zero(zero),
    .carry(carry), .div_by_zero(div_by_zero), .busy(busy), .done(done), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // outputs packed as {saidaULA, carry, zero, div_by_zero, busy, done}
  function automatic logic [12:0] obs();
    return {saidaULA, carry, zero, div_by_zero, busy, done};
  endfunction

  // behavioural reference: plain integer arithmetic, memory as an int array
  task automatic model(input int op, input int x, input int y, input int ad,
                       output logic [12:0] exp);
    int r, c, d;
    r = 0; c = 0; d = 0;
    case (op)
      1:  begin r = (x + y) % 256; c = (x + y > 255); end
      2:  begin r = (x - y + 256) % 256; c = (x < y); end
      3:  begin r = (x * y) % 256; c = (x * y > 255); end
      4:  if (y == 0) begin r = 255; d = 1; end else r = x / y;
      5:  r = x & y;
      6:  r = x | y;
      7, 11: r = 255 - x;
      8:  r = x ^ y;
      9:  r = 255 - (x ^ y);
      10: r = x;
      12: begin r = x; if (ad < DEPTH) mref[ad] = x; end
      13: r = (ad < DEPTH) ? mref[ad] : 0;
      default: r = 0;
    endcase
    exp = {8'(r), c[0], (r == 0), d[0], 1'b0, 1'b1};
  endtask

  task automatic issue(input int op, input int x, input int y, input int ad);
    opcode = 4'(op); a = 8'(x); b = 8'(y); endereco = 4'(ad); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    foreach (mref[i]) mref[i] = 0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs() !== 13'h0) begin
      n_bad++; $display("FAIL reset_outputs got %h exp %h", obs(), 13'h0);
    end
  endtask

  task automatic test_arith();
    logic [12:0] exp;
    int ops [4] = '{1, 2, 3, 2};
    int xs  [4] = '{200, 5, 20, 9};
    int ys  [4] = '{100, 7, 20, 9};
    int rs  [4] = '{44, 254, 144, 0};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], xs[i], ys[i], 0);
      exp = {8'(rs[i]), (i < 3), (rs[i] == 0), 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++; $display("FAIL arith_%0d got %h exp %h", i, obs(), exp);
      end
    end
    @(posedge clock); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle got %b exp 0", done); end
  endtask

  task automatic test_divide();
    int cnt;
    logic [W-1:0] held;
    held = saidaULA;
    issue(4, 200, 7, 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      n_cmp++;
      if (saidaULA !== held || done !== 1'b0) begin
        n_bad++; $display("FAIL div_hold got %0d/%b exp %0d/0", saidaULA, done, held);
      end
      if (cnt == 3) begin start = 1'b1; opcode = 4'd1; a = 8'd1; b = 8'd1; end
      else start = 1'b0;
      @(posedge clock); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (cnt != 8) begin n_bad++; $display("FAIL div_busy_cycles got %0d exp 8", cnt); end
    n_cmp++;
    if (obs() !== {8'd28, 5'b00001}) begin
      n_bad++; $display("FAIL div_result got %h exp %h", obs(), {8'd28, 5'b00001});
    end
    issue(1, 1, 2, 0);
    n_cmp++;
    if (obs() !== {8'd3, 5'b00001}) begin
      n_bad++; $display("FAIL after_div_start got %h exp %h", obs(), {8'd3, 5'b00001});
    end
  endtask

  task automatic test_div_zero();
    logic seen_busy;
    issue(4, 5, 0, 0);
    seen_busy = busy;
    n_cmp++;
    if (obs() !== {8'd255, 5'b00101}) begin
      n_bad++; $display("FAIL div0 got %h exp %h", obs(), {8'd255, 5'b00101});
    end
    @(posedge clock); #1;
    seen_busy |= busy;
    n_cmp++;
    if (seen_busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL div0_busy got %b/%b exp 0/0", seen_busy, done);
    end
    issue(1, 1, 1, 0);
    n_cmp++;
    if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL div0_clear got %b exp 0", div_by_zero); end
  endtask

  task automatic test_memory();
    logic [12:0] exp;
    rd_endereco = 4'd3;
    model(12, 8'hA5, 0, 3, exp);
    issue(12, 8'hA5, 0, 3);
    n_cmp++;
    if (mem_rdata !== 8'hA5 || obs() !== exp) begin
      n_bad++; $display("FAIL store got %h/%h exp a5/%h", mem_rdata, obs(), exp);
    end
    issue(13, 0, 0, 3);
    n_cmp++;
    if (saidaULA !== 8'hA5) begin n_bad++; $display("FAIL load got %h exp a5", saidaULA); end
    rd_endereco = 4'd15;
    issue(12, 8'h5A, 0, 15);
    n_cmp++;
    if (mem_rdata !== 8'h00) begin n_bad++; $display("FAIL oob_rdata got %h exp 0", mem_rdata); end
    issue(13, 0, 0, 15);
    n_cmp++;
    if (saidaULA !== 8'h00 || zero !== 1'b1) begin
      n_bad++; $display("FAIL oob_load got %h/%b exp 0/1", saidaULA, zero);
    end
  endtask

  task automatic test_reset_mid_div();
    issue(4, 200, 7, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    rd_endereco = 4'd3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 13'h0 || mem_rdata !== 8'h0) begin
      n_bad++; $display("FAIL reset_mid_div got %h/%h exp 0/0", obs(), mem_rdata);
    end
    foreach (mref[i]) mref[i] = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    issue(1, 3, 4, 0);
    n_cmp++;
    if (obs() !== {8'd7, 5'b00001}) begin
      n_bad++; $display("FAIL post_reset_add got %h exp %h", obs(), {8'd7, 5'b00001});
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    int op, x, y, ad, ra, lim;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15); x = $urandom_range(0, 255);
      y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      ad = $urandom_range(0, 15);
      model(op, x, y, ad, exp);
      issue(op, x, y, ad);
      lim = 0;
      while (busy === 1'b1 && lim < 20) begin lim++; @(posedge clock); #1; end
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++; $display("FAIL rand_op%0d_%0d got %h exp %h", op, i, obs(), exp);
      end
      ra = $urandom_range(0, 15);
      rd_endereco = 4'(ra);
      #1;
      n_cmp++;
      if (mem_rdata !== 8'((ra < DEPTH) ? mref[ra] : 0)) begin
        n_bad++; $display("FAIL rand_rdata_%0d got %h exp %h", ra, mem_rdata,
                          8'((ra < DEPTH) ? mref[ra] : 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_divide();
    test_div_zero();
    test_memory();
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
